// File: rtl/pkt_ingress_buffer.sv
// Store-and-forward ingress buffer: byte AXIS in, whole committed packets plus one metadata word
// per packet out. Define PKT_INGRESS_DROP_CNT_EN to add the saturating drop_count output.
module pkt_ingress_buffer #(
    parameter int unsigned DATA_DEPTH  = 2048,
    parameter int unsigned META_DEPTH  = 16,
    parameter int unsigned MAX_PKT_LEN = 1518
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_axis_tvalid,
    input  logic [7:0]  in_axis_tdata,
    input  logic        in_axis_tlast,
    output logic        in_axis_tready,
    output logic        buf_axis_tvalid,
    output logic [7:0]  buf_axis_tdata,
    output logic        buf_axis_tlast,
    input  logic        buf_axis_tready,
`ifdef PKT_INGRESS_DROP_CNT_EN
    output logic [15:0] drop_count,
`endif
    output logic        meta_axis_tvalid,
    output logic [31:0] meta_axis_tdata,
    input  logic        meta_axis_tready
);

    localparam int unsigned AW  = $clog2(DATA_DEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned MAW = $clog2(META_DEPTH);
    localparam int unsigned MPW = MAW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StDrop
    } state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [15:0]    len_q, len_d;
    logic [7:0]     dest_q, dest_d;
    logic [MPW-1:0] meta_wr_q, meta_wr_d;
    logic [MPW-1:0] meta_rd_q, meta_rd_d;
    logic           out_valid_q, out_valid_d;
    logic [7:0]     out_data_q, out_data_d;
    logic           out_last_q, out_last_d;

    logic [8:0]     data_mem [DATA_DEPTH];
    logic [31:0]    meta_mem [META_DEPTH];

    logic           ready_int;
    logic           accept;
    logic           data_full;
    logic           meta_full;
    logic           data_we;
    logic           meta_push;
    logic           meta_pop;
    logic           drop_evt;
    logic           rd_load;
    logic [31:0]    meta_word;
    logic [PW-1:0]  data_used;
    logic [MPW-1:0] meta_used;
    logic [8:0]     rd_entry;

    // Occupancy uses the registered read pointer, so a same-cycle read never frees a slot early.
    assign data_used = wr_ptr_q - rd_ptr_q;
    assign data_full = (data_used == PW'(DATA_DEPTH));
    assign meta_used = meta_wr_q - meta_rd_q;
    assign meta_full = (meta_used == MPW'(META_DEPTH));

    assign in_axis_tready = resetn & ready_int;
    assign accept         = in_axis_tvalid & in_axis_tready;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        len_d        = len_q;
        dest_d       = dest_q;
        ready_int    = 1'b0;
        data_we      = 1'b0;
        meta_push    = 1'b0;
        drop_evt     = 1'b0;
        meta_word    = {8'h00, dest_q, len_q};
        unique case (state_q)
            StIdle: begin
                ready_int = !meta_full;
                if (accept) begin
                    if (data_full) begin
                        drop_evt = 1'b1;
                        state_d  = in_axis_tlast ? StIdle : StDrop;
                    end else begin
                        data_we  = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        dest_d   = in_axis_tdata;
                        len_d    = 16'd1;
                        if (in_axis_tlast) begin
                            commit_ptr_d = wr_ptr_q + PW'(1);
                            meta_push    = 1'b1;
                            meta_word    = {8'h00, in_axis_tdata, 16'd1};
                        end else begin
                            state_d = StRecv;
                        end
                    end
                end
            end
            StRecv: begin
                ready_int = 1'b1;
                if (accept) begin
                    if (data_full || (len_q == 16'(MAX_PKT_LEN))) begin
                        drop_evt = 1'b1;
                        state_d  = in_axis_tlast ? StIdle : StDrop;
                    end else begin
                        data_we  = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        len_d    = len_q + 16'd1;
                        if (in_axis_tlast) begin
                            commit_ptr_d = wr_ptr_q + PW'(1);
                            meta_push    = 1'b1;
                            meta_word    = {8'h00, dest_q, len_q + 16'd1};
                            state_d      = StIdle;
                        end
                    end
                end
            end
            StDrop: begin
                ready_int = 1'b1;
                if (accept && in_axis_tlast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Rewind the tentative pointer so the partial packet is never seen downstream.
        if (drop_evt) begin
            wr_ptr_d = commit_ptr_q;
        end
    end

    // Registered output stage; it only ever pulls entries below commit_ptr.
    assign rd_entry = data_mem[rd_ptr_q[AW-1:0]];
    assign rd_load  = (rd_ptr_q != commit_ptr_q) && (!out_valid_q || buf_axis_tready);

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (rd_load) begin
            rd_ptr_d    = rd_ptr_q + PW'(1);
            out_valid_d = 1'b1;
            out_data_d  = rd_entry[7:0];
            out_last_d  = rd_entry[8];
        end else if (buf_axis_tready) begin
            out_valid_d = 1'b0;
        end
    end

    assign buf_axis_tvalid = out_valid_q;
    assign buf_axis_tdata  = out_data_q;
    assign buf_axis_tlast  = out_last_q;

    assign meta_axis_tvalid = (meta_wr_q != meta_rd_q);
    assign meta_axis_tdata  = meta_axis_tvalid ? meta_mem[meta_rd_q[MAW-1:0]] : 32'h0;
    assign meta_pop         = meta_axis_tvalid & meta_axis_tready;

    always_comb begin
        meta_wr_d = meta_wr_q;
        meta_rd_d = meta_rd_q;
        if (meta_push) begin
            meta_wr_d = meta_wr_q + MPW'(1);
        end
        if (meta_pop) begin
            meta_rd_d = meta_rd_q + MPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[wr_ptr_q[AW-1:0]] <= {in_axis_tlast, in_axis_tdata};
        end
        if (meta_push) begin
            meta_mem[meta_wr_q[MAW-1:0]] <= meta_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            len_q        <= '0;
            dest_q       <= '0;
            meta_wr_q    <= '0;
            meta_rd_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            len_q        <= len_d;
            dest_q       <= dest_d;
            meta_wr_q    <= meta_wr_d;
            meta_rd_q    <= meta_rd_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
        end
    end

`ifdef PKT_INGRESS_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_evt && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pkt_ingress_buffer.sv
// Scoreboard bench for pkt_ingress_buffer with a small data FIFO so overflow and
// max-length drops are reachable with short packets.
`timescale 1ns/1ps
module tb_pkt_ingress_buffer;

    localparam int unsigned DataDepth = 16;
    localparam int unsigned MetaDepth = 4;
    localparam int unsigned MaxLen    = 12;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_axis_tvalid;
    logic [7:0]  in_axis_tdata;
    logic        in_axis_tlast;
    logic        in_axis_tready;
    logic        buf_axis_tvalid;
    logic [7:0]  buf_axis_tdata;
    logic        buf_axis_tlast;
    logic        buf_axis_tready;
    logic        meta_axis_tvalid;
    logic [31:0] meta_axis_tdata;
    logic        meta_axis_tready;
`ifdef PKT_INGRESS_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    logic [8:0]  exp_buf[$];
    logic [31:0] exp_meta[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    pkt_ingress_buffer #(
        .DATA_DEPTH  (DataDepth),
        .META_DEPTH  (MetaDepth),
        .MAX_PKT_LEN (MaxLen)
    ) u_dut (
        .clk              (clk),
        .resetn           (resetn),
        .in_axis_tvalid   (in_axis_tvalid),
        .in_axis_tdata    (in_axis_tdata),
        .in_axis_tlast    (in_axis_tlast),
        .in_axis_tready   (in_axis_tready),
        .buf_axis_tvalid  (buf_axis_tvalid),
        .buf_axis_tdata   (buf_axis_tdata),
        .buf_axis_tlast   (buf_axis_tlast),
        .buf_axis_tready  (buf_axis_tready),
`ifdef PKT_INGRESS_DROP_CNT_EN
        .drop_count       (drop_count),
`endif
        .meta_axis_tvalid (meta_axis_tvalid),
        .meta_axis_tdata  (meta_axis_tdata),
        .meta_axis_tready (meta_axis_tready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Handshakes complete on the next posedge; inputs only change at posedge+1.
    always @(negedge clk) begin
        if (resetn && buf_axis_tvalid && buf_axis_tready) begin
            if (exp_buf.size() == 0) begin
                check("buf_beat_expected", 32'(exp_buf.size()), 32'd1);
            end else begin
                check("buf_beat", {23'd0, buf_axis_tlast, buf_axis_tdata},
                      {23'd0, exp_buf.pop_front()});
            end
        end
        if (resetn && meta_axis_tvalid && meta_axis_tready) begin
            if (exp_meta.size() == 0) begin
                check("meta_word_expected", 32'(exp_meta.size()), 32'd1);
            end else begin
                check("meta_word", meta_axis_tdata, exp_meta.pop_front());
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic l);
        int waited = 0;
        in_axis_tvalid = 1'b1;
        in_axis_tdata  = d;
        in_axis_tlast  = l;
        @(negedge clk);
        while (!in_axis_tready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_axis_tready) begin
            check("in_tready_timeout", 32'(in_axis_tready), 32'd1);
        end
        @(posedge clk);
        #1;
        in_axis_tvalid = 1'b0;
        in_axis_tlast  = 1'b0;
    endtask

    // Byte 0 is the destination; byte i>0 is seed + 17*i.
    task automatic send_pkt(input int n, input logic [7:0] dest, input logic [7:0] seed,
                            input bit commit, input bit hold_chk);
        logic [7:0] b;
        logic       lst;
        if (commit) begin
            exp_meta.push_back({8'h00, dest, 16'(n)});
            for (int i = 0; i < n; i++) begin
                b   = (i == 0) ? dest : seed + 8'(17 * i);
                lst = (i == n - 1);
                exp_buf.push_back({lst, b});
            end
        end
        for (int i = 0; i < n; i++) begin
            b   = (i == 0) ? dest : seed + 8'(17 * i);
            lst = (i == n - 1);
            send_beat(b, lst);
            if (hold_chk && !lst) begin
                @(negedge clk);
                check("buf_valid_before_commit", 32'(buf_axis_tvalid), 32'd0);
                @(posedge clk);
                #1;
            end else if (!lst && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain(input string tag);
        int cyc = 0;
        while ((exp_buf.size() != 0 || exp_meta.size() != 0) && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_pending"}, 32'(exp_buf.size() + exp_meta.size()), 32'd0);
        @(negedge clk);
        check({tag, "_buf_idle"}, 32'(buf_axis_tvalid), 32'd0);
        check({tag, "_meta_idle"}, 32'(meta_axis_tvalid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        resetn           = 1'b0;
        in_axis_tvalid   = 1'b0;
        in_axis_tdata    = 8'h00;
        in_axis_tlast    = 1'b0;
        buf_axis_tready  = 1'b0;
        meta_axis_tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_tready", 32'(in_axis_tready), 32'd0);
        check("rst_buf_tvalid", 32'(buf_axis_tvalid), 32'd0);
        check("rst_buf_tdata", 32'(buf_axis_tdata), 32'd0);
        check("rst_buf_tlast", 32'(buf_axis_tlast), 32'd0);
        check("rst_meta_tvalid", 32'(meta_axis_tvalid), 32'd0);
        check("rst_meta_tdata", meta_axis_tdata, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_in_tready", 32'(in_axis_tready), 32'd1);
        @(posedge clk);
        #1;

        // 4-byte packet; buf must stay idle until tlast is accepted.
        buf_axis_tready = 1'b1;
        send_pkt(4, 8'h03, 8'h99, 1'b1, 1'b1);
        @(negedge clk);
        check("t1_meta_valid", 32'(meta_axis_tvalid), 32'd1);
        check("t1_meta_word", meta_axis_tdata, 32'h0003_0004);
        @(negedge clk);
        check("t1_buf_latency", 32'(buf_axis_tvalid), 32'd1);
        @(posedge clk);
        #1;
        meta_axis_tready = 1'b1;
        wait_drain("t1");

        // Single-byte packet.
        send_pkt(1, 8'h05, 8'h00, 1'b1, 1'b0);
        wait_drain("t2");

        // Overflow while downstream is stalled: second packet is dropped whole.
        buf_axis_tready = 1'b0;
        send_pkt(10, 8'h07, 8'h10, 1'b1, 1'b0);
        send_pkt(8, 8'h08, 8'h40, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t3_meta_popped", 32'(exp_meta.size()), 32'd0);
        check("t3_buf_stalled_valid", 32'(buf_axis_tvalid), 32'd1);
`ifdef PKT_INGRESS_DROP_CNT_EN
        check("t3_drop_count", 32'(drop_count), 32'd1);
`endif
        buf_axis_tready = 1'b1;
        wait_drain("t3a");
        send_pkt(6, 8'h09, 8'h60, 1'b1, 1'b0);
        wait_drain("t3b");

        // Length limit: MaxLen+1 dropped on its tlast, longer one via the drop state.
        send_pkt(MaxLen + 1, 8'h0A, 8'h20, 1'b0, 1'b0);
        send_pkt(2, 8'h0B, 8'h30, 1'b1, 1'b0);
        wait_drain("t4a");
        send_pkt(MaxLen + 4, 8'h0C, 8'h40, 1'b0, 1'b0);
        send_pkt(MaxLen, 8'h0D, 8'h50, 1'b1, 1'b0);
        wait_drain("t4b");
`ifdef PKT_INGRESS_DROP_CNT_EN
        check("t4_drop_count", 32'(drop_count), 32'd3);
`endif

        // Metadata FIFO full blocks new packets in idle.
        meta_axis_tready = 1'b0;
        for (int k = 0; k < int'(MetaDepth); k++) begin
            send_pkt(1, 8'h20 + 8'(k), 8'h00, 1'b1, 1'b0);
        end
        @(negedge clk);
        check("t5_in_tready_meta_full", 32'(in_axis_tready), 32'd0);
        check("t5_meta_valid", 32'(meta_axis_tvalid), 32'd1);
        @(posedge clk);
        #1;
        meta_axis_tready = 1'b1;
        @(posedge clk);
        #1;
        meta_axis_tready = 1'b0;
        @(negedge clk);
        check("t5_in_tready_after_pop", 32'(in_axis_tready), 32'd1);
        @(posedge clk);
        #1;
        meta_axis_tready = 1'b1;
        wait_drain("t5");

        // Reset while a committed packet is draining and another is half received.
        buf_axis_tready  = 1'b0;
        meta_axis_tready = 1'b0;
        send_pkt(3, 8'h0E, 8'h70, 1'b1, 1'b0);
        send_beat(8'h0F, 1'b0);
        send_beat(8'h11, 1'b0);
        buf_axis_tready = 1'b1;
        resetn          = 1'b0;
        @(negedge clk);
        check("t6_in_tready_in_reset", 32'(in_axis_tready), 32'd0);
        @(posedge clk);
        #1;
        exp_buf.delete();
        exp_meta.delete();
        @(negedge clk);
        check("t6_buf_valid_reset", 32'(buf_axis_tvalid), 32'd0);
        check("t6_meta_valid_reset", 32'(meta_axis_tvalid), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check("t6_in_tready_release", 32'(in_axis_tready), 32'd1);
        check("t6_buf_empty", 32'(buf_axis_tvalid), 32'd0);
        check("t6_meta_empty", 32'(meta_axis_tvalid), 32'd0);
        @(posedge clk);
        #1;
        meta_axis_tready = 1'b1;
        send_pkt(5, 8'h12, 8'h80, 1'b1, 1'b0);
        wait_drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
